// File: rtl/rf_pkg.sv
// rf_pkg: shared constants and types for the multi-port register file.
//   RF_ZERO_IDX  register that is hardwired to zero
//   RF_SP_IDX    default stack-pointer register index
//   RF_SP_RESET  default stack-pointer reset value
//   RF_BR_REG    default register forced onto read port 1 for branch compares
//   rf_waddr_t / rf_data_t  default-width address and data types
package rf_pkg;

    localparam int RF_DW       = 16;
    localparam int RF_NREGS    = 16;
    localparam int RF_AW       = 4;
    localparam int RF_NREAD    = 2;

    localparam int RF_ZERO_IDX = 0;
    localparam int RF_SP_IDX   = 2;
    localparam logic [RF_DW-1:0] RF_SP_RESET = 16'h03FF;
    localparam int RF_BR_REG   = 14;

    typedef logic [RF_AW-1:0] rf_waddr_t;
    typedef logic [RF_DW-1:0] rf_data_t;

endpackage

// File: rtl/rf_read_port.sv
// rf_read_port: one registered read port of the register file.
//   CLK, RST_N         clock / async active-low reset
//   rd_en              load the output registers this edge (otherwise hold)
//   rd_addr            requested register address
//   br_sig             replace rd_addr with BR_REG (tied low on ports without the override)
//   wr_en/addr/data    the two write ports, used for write-first bypass
//   regs               current register contents
//   pend_next          scoreboard value after this edge's set/clear
//   rd_data, rd_pend   registered read data and pending flag
module rf_read_port
    import rf_pkg::*;
#(
    parameter int DW     = RF_DW,
    parameter int NREGS  = RF_NREGS,
    parameter int AW     = RF_AW,
    parameter int BR_REG = RF_BR_REG
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    input  logic              br_sig,
    input  logic [1:0]        wr_en,
    input  logic [2*AW-1:0]   wr_addr,
    input  logic [2*DW-1:0]   wr_data,
    input  logic [DW-1:0]     regs [NREGS],
    input  logic [NREGS-1:0]  pend_next,
    output logic [DW-1:0]     rd_data,
    output logic              rd_pend
);

    logic [AW-1:0] eff_addr;
    logic          eff_zero;
    logic          hit0;
    logic          hit1;
    logic [DW-1:0] data_next;
    logic          pend_bit_next;
    logic [DW-1:0] data_reg;
    logic          pend_reg;

    assign eff_addr = br_sig ? AW'(BR_REG) : rd_addr;
    assign eff_zero = (eff_addr == AW'(RF_ZERO_IDX));

    assign hit0 = wr_en[0] && (wr_addr[0 +: AW]  == eff_addr);
    assign hit1 = wr_en[1] && (wr_addr[AW +: AW] == eff_addr);

    // Write-first: a same-cycle write to the address wins over the stored value,
    // and port 1 wins over port 0, matching the storage update order.
    always_comb begin
        data_next = regs[eff_addr];
        if (eff_zero) begin
            data_next = '0;
        end else if (hit1) begin
            data_next = wr_data[DW +: DW];
        end else if (hit0) begin
            data_next = wr_data[0 +: DW];
        end
    end

    assign pend_bit_next = pend_next[eff_addr] && !eff_zero;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            data_reg <= '0;
            pend_reg <= 1'b0;
        end else if (rd_en) begin
            data_reg <= data_next;
            pend_reg <= pend_bit_next;
        end
    end

    assign rd_data = data_reg;
    assign rd_pend = pend_reg;

endmodule

// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port register file between decode and execute.
//   CLK, RST_N     clock / async active-low reset
//   in_RdEn        per-read-port load enable
//   in_ReadAddr    read addresses, port k at [k*AW +: AW]
//   in_BrSig       force read port 1 onto BR_REG
//   in_WrEn        two write enables (port 1 wins on address collision)
//   in_WrAddr      two write addresses
//   in_WrData      two write data words
//   in_SetPend     mark in_PendAddr as awaiting a producer
//   in_PendAddr    register to mark pending
//   out_ReadData   registered read data per port
//   out_ReadPend   registered pending flag per port
// Register 0 reads as zero and is never pending; SP_IDX only changes the reset value.
module reg_file_mp
    import rf_pkg::*;
#(
    parameter int             DW       = RF_DW,
    parameter int             NREGS    = RF_NREGS,
    parameter int             AW       = RF_AW,
    parameter int             NREAD    = RF_NREAD,
    parameter int             SP_IDX   = RF_SP_IDX,
    parameter logic [DW-1:0]  SP_RESET = RF_SP_RESET,
    parameter int             BR_REG   = RF_BR_REG
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic [NREAD-1:0]     in_RdEn,
    input  logic [NREAD*AW-1:0]  in_ReadAddr,
    input  logic                 in_BrSig,
    input  logic [1:0]           in_WrEn,
    input  logic [2*AW-1:0]      in_WrAddr,
    input  logic [2*DW-1:0]      in_WrData,
    input  logic                 in_SetPend,
    input  logic [AW-1:0]        in_PendAddr,
    output logic [NREAD*DW-1:0]  out_ReadData,
    output logic [NREAD-1:0]     out_ReadPend
);

    logic [DW-1:0]    regs_reg [NREGS];
    logic [NREGS-1:0] pend_reg;
    logic [NREGS-1:0] pend_next;

    logic [AW-1:0] wr_addr0;
    logic [AW-1:0] wr_addr1;
    logic [DW-1:0] wr_data0;
    logic [DW-1:0] wr_data1;

    assign wr_addr0 = in_WrAddr[0 +: AW];
    assign wr_addr1 = in_WrAddr[AW +: AW];
    assign wr_data0 = in_WrData[0 +: DW];
    assign wr_data1 = in_WrData[DW +: DW];

    // Storage and scoreboard, one slice per register.
    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_reg
            if (gi == RF_ZERO_IDX) begin : g_zero
                always_ff @(posedge CLK or negedge RST_N) begin
                    if (!RST_N) begin
                        regs_reg[gi] <= '0;
                    end else begin
                        regs_reg[gi] <= '0;
                    end
                end
                assign pend_next[gi] = 1'b0;
            end else begin : g_data
                logic hit0;
                logic hit1;
                logic set_hit;

                assign hit0    = in_WrEn[0] && (wr_addr0 == AW'(gi));
                assign hit1    = in_WrEn[1] && (wr_addr1 == AW'(gi));
                assign set_hit = in_SetPend && (in_PendAddr == AW'(gi));

                always_ff @(posedge CLK or negedge RST_N) begin
                    if (!RST_N) begin
                        regs_reg[gi] <= (gi == SP_IDX) ? SP_RESET : '0;
                    end else if (hit1) begin
                        regs_reg[gi] <= wr_data1;
                    end else if (hit0) begin
                        regs_reg[gi] <= wr_data0;
                    end
                end

                // A new producer being issued outranks the completing write.
                assign pend_next[gi] = set_hit ? 1'b1
                                     : ((hit0 || hit1) ? 1'b0 : pend_reg[gi]);
            end
        end
    endgenerate

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pend_reg <= '0;
        end else begin
            pend_reg <= pend_next;
        end
    end

    // Read ports; only port 1 honours the branch-compare override.
    generate
        for (gi = 0; gi < NREAD; gi++) begin : g_port
            localparam logic IS_BR_PORT = (gi == 1);
            logic br_sel;

            assign br_sel = in_BrSig && IS_BR_PORT;

            rf_read_port #(
                .DW     (DW),
                .NREGS  (NREGS),
                .AW     (AW),
                .BR_REG (BR_REG)
            ) u_read_port (
                .CLK       (CLK),
                .RST_N     (RST_N),
                .rd_en     (in_RdEn[gi]),
                .rd_addr   (in_ReadAddr[gi*AW +: AW]),
                .br_sig    (br_sel),
                .wr_en     (in_WrEn),
                .wr_addr   (in_WrAddr),
                .wr_data   (in_WrData),
                .regs      (regs_reg),
                .pend_next (pend_next),
                .rd_data   (out_ReadData[gi*DW +: DW]),
                .rd_pend   (out_ReadPend[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_reg_file_mp.sv
module tb_reg_file_mp;

    localparam int DW = 16;
    localparam int NREGS = 16;
    localparam int AW = 4;
    localparam int NREAD = 2;

    logic                CLK = 1'b0;
    logic                RST_N;
    logic [NREAD-1:0]    in_RdEn;
    logic [NREAD*AW-1:0] in_ReadAddr;
    logic                in_BrSig;
    logic [1:0]          in_WrEn;
    logic [2*AW-1:0]     in_WrAddr;
    logic [2*DW-1:0]     in_WrData;
    logic                in_SetPend;
    logic [AW-1:0]       in_PendAddr;
    logic [NREAD*DW-1:0] out_ReadData;
    logic [NREAD-1:0]    out_ReadPend;

    // Stimulus variables; the DUT buses are packed from these.
    logic [1:0]  rd_en;
    logic [3:0]  ra0, ra1;
    logic        br;
    logic [1:0]  wr_en;
    logic [3:0]  wa0, wa1;
    logic [15:0] wd0, wd1;
    logic        setp;
    logic [3:0]  pa;

    assign in_RdEn     = rd_en;
    assign in_ReadAddr = {ra1, ra0};
    assign in_BrSig    = br;
    assign in_WrEn     = wr_en;
    assign in_WrAddr   = {wa1, wa0};
    assign in_WrData   = {wd1, wd0};
    assign in_SetPend  = setp;
    assign in_PendAddr = pa;

    always #5 CLK = ~CLK;

    reg_file_mp dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .in_RdEn      (in_RdEn),
        .in_ReadAddr  (in_ReadAddr),
        .in_BrSig     (in_BrSig),
        .in_WrEn      (in_WrEn),
        .in_WrAddr    (in_WrAddr),
        .in_WrData    (in_WrData),
        .in_SetPend   (in_SetPend),
        .in_PendAddr  (in_PendAddr),
        .out_ReadData (out_ReadData),
        .out_ReadPend (out_ReadPend)
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference model: architectural registers, pending set and output latches.
    logic [15:0] m_mem [16];
    logic        m_pend [16];
    logic [15:0] m_d [2];
    logic        m_p [2];

    task automatic model_reset();
        for (int r = 0; r < 16; r++) begin
            m_mem[r]  = 16'h0;
            m_pend[r] = 1'b0;
        end
        m_mem[2] = 16'h03FF;
        for (int k = 0; k < 2; k++) begin
            m_d[k] = 16'h0;
            m_p[k] = 1'b0;
        end
    endtask

    task automatic model_step();
        logic [15:0] nm [16];
        logic        np [16];
        logic [3:0]  wa [2];
        logic [15:0] wd [2];
        logic [3:0]  ra [2];
        logic [3:0]  ea;
        wa[0] = wa0; wa[1] = wa1; wd[0] = wd0; wd[1] = wd1;
        ra[0] = ra0; ra[1] = ra1;
        for (int r = 0; r < 16; r++) begin
            nm[r] = m_mem[r];
            np[r] = m_pend[r];
        end
        // Port 0 applied first so port 1 overwrites it on collision.
        for (int p = 0; p < 2; p++) begin
            if (wr_en[p]) begin
                nm[wa[p]] = wd[p];
                np[wa[p]] = 1'b0;
            end
        end
        if (setp) np[pa] = 1'b1;
        nm[0] = 16'h0;
        np[0] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            if (rd_en[k]) begin
                ea = (k == 1 && br) ? 4'd14 : ra[k];
                m_d[k] = nm[ea];
                m_p[k] = np[ea];
            end
        end
        for (int r = 0; r < 16; r++) begin
            m_mem[r]  = nm[r];
            m_pend[r] = np[r];
        end
    endtask

    task automatic idle_inputs();
        rd_en = 2'b00; ra0 = 4'd0; ra1 = 4'd0; br = 1'b0;
        wr_en = 2'b00; wa0 = 4'd0; wa1 = 4'd0; wd0 = 16'h0; wd1 = 16'h0;
        setp = 1'b0; pa = 4'd0;
    endtask

    // Advance one clock with the current inputs; outputs are sampled 1 time unit after the edge.
    task automatic step();
        model_step();
        @(posedge CLK);
        #1;
    endtask

    typedef struct {
        logic [1:0]  rd_en;
        logic [3:0]  ra0, ra1;
        logic        br;
        logic [1:0]  wr_en;
        logic [3:0]  wa0;
        logic [15:0] wd0;
        logic [3:0]  wa1;
        logic [15:0] wd1;
        logic        setp;
        logic [3:0]  pa;
        logic [15:0] e_d0, e_d1;
        logic        e_p0, e_p1;
    } vec_t;

    vec_t vecs [11];

    initial begin
        // rd_en ra0 ra1 br wr_en wa0 wd0 wa1 wd1 setp pa | d0 d1 p0 p1
        vecs[0]  = '{2'b00, 4'd0, 4'd0, 1'b0, 2'b01, 4'd5,  16'h1234, 4'd0,  16'h0000, 1'b0, 4'd0, 16'h0000, 16'h0000, 1'b0, 1'b0};
        vecs[1]  = '{2'b11, 4'd5, 4'd2, 1'b0, 2'b00, 4'd0,  16'h0000, 4'd0,  16'h0000, 1'b0, 4'd0, 16'h1234, 16'h03FF, 1'b0, 1'b0};
        vecs[2]  = '{2'b01, 4'd7, 4'd0, 1'b0, 2'b11, 4'd7,  16'hAAAA, 4'd7,  16'h5555, 1'b0, 4'd0, 16'h5555, 16'h03FF, 1'b0, 1'b0};
        vecs[3]  = '{2'b01, 4'd7, 4'd0, 1'b0, 2'b00, 4'd0,  16'h0000, 4'd0,  16'h0000, 1'b0, 4'd0, 16'h5555, 16'h03FF, 1'b0, 1'b0};
        vecs[4]  = '{2'b11, 4'd0, 4'd0, 1'b0, 2'b01, 4'd0,  16'hFFFF, 4'd0,  16'h0000, 1'b1, 4'd0, 16'h0000, 16'h0000, 1'b0, 1'b0};
        vecs[5]  = '{2'b00, 4'd0, 4'd0, 1'b0, 2'b10, 4'd0,  16'h0000, 4'd14, 16'h00F0, 1'b0, 4'd0, 16'h0000, 16'h0000, 1'b0, 1'b0};
        vecs[6]  = '{2'b11, 4'd5, 4'd3, 1'b1, 2'b00, 4'd0,  16'h0000, 4'd0,  16'h0000, 1'b0, 4'd0, 16'h1234, 16'h00F0, 1'b0, 1'b0};
        vecs[7]  = '{2'b11, 4'd9, 4'd9, 1'b0, 2'b00, 4'd0,  16'h0000, 4'd0,  16'h0000, 1'b1, 4'd9, 16'h0000, 16'h0000, 1'b1, 1'b1};
        vecs[8]  = '{2'b01, 4'd9, 4'd0, 1'b0, 2'b01, 4'd9,  16'h0909, 4'd0,  16'h0000, 1'b1, 4'd9, 16'h0909, 16'h0000, 1'b1, 1'b1};
        vecs[9]  = '{2'b11, 4'd9, 4'd5, 1'b0, 2'b10, 4'd0,  16'h0000, 4'd9,  16'h0A0A, 1'b0, 4'd0, 16'h0A0A, 16'h1234, 1'b0, 1'b0};
        vecs[10] = '{2'b11, 4'd2, 4'd2, 1'b0, 2'b01, 4'd2,  16'h1111, 4'd0,  16'h0000, 1'b0, 4'd0, 16'h1111, 16'h1111, 1'b0, 1'b0};

        // Power-on reset.
        RST_N = 1'b0;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        #1;
        check("reset_d0", {16'h0, out_ReadData[15:0]},  32'h0);
        check("reset_d1", {16'h0, out_ReadData[31:16]}, 32'h0);
        check("reset_pend", {30'h0, out_ReadPend}, 32'h0);

        // Directed table.
        for (int i = 0; i < 11; i++) begin
            rd_en = vecs[i].rd_en; ra0 = vecs[i].ra0; ra1 = vecs[i].ra1; br = vecs[i].br;
            wr_en = vecs[i].wr_en; wa0 = vecs[i].wa0; wd0 = vecs[i].wd0;
            wa1 = vecs[i].wa1; wd1 = vecs[i].wd1; setp = vecs[i].setp; pa = vecs[i].pa;
            step();
            $display("vec %0d: d0=%h d1=%h p=%b", i, out_ReadData[15:0], out_ReadData[31:16], out_ReadPend);
            check($sformatf("vec%0d_d0", i), {16'h0, out_ReadData[15:0]},  {16'h0, vecs[i].e_d0});
            check($sformatf("vec%0d_d1", i), {16'h0, out_ReadData[31:16]}, {16'h0, vecs[i].e_d1});
            check($sformatf("vec%0d_p0", i), {31'h0, out_ReadPend[0]}, {31'h0, vecs[i].e_p0});
            check($sformatf("vec%0d_p1", i), {31'h0, out_ReadPend[1]}, {31'h0, vecs[i].e_p1});
        end

        // Randomised traffic against the reference model.
        for (int c = 0; c < 400; c++) begin
            rd_en = 2'($urandom);
            ra0 = 4'($urandom); ra1 = 4'($urandom);
            br = ($urandom_range(0, 3) == 0);
            wr_en = 2'($urandom);
            wa0 = 4'($urandom); wa1 = ($urandom_range(0, 3) == 0) ? wa0 : 4'($urandom);
            wd0 = 16'($urandom); wd1 = 16'($urandom);
            setp = ($urandom_range(0, 2) == 0);
            pa = ($urandom_range(0, 3) == 0) ? wa0 : 4'($urandom);
            step();
            $display("rnd %0d: d0=%h d1=%h p=%b", c, out_ReadData[15:0], out_ReadData[31:16], out_ReadPend);
            check("rnd_d0", {16'h0, out_ReadData[15:0]},  {16'h0, m_d[0]});
            check("rnd_d1", {16'h0, out_ReadData[31:16]}, {16'h0, m_d[1]});
            check("rnd_p0", {31'h0, out_ReadPend[0]}, {31'h0, m_p[0]});
            check("rnd_p1", {31'h0, out_ReadPend[1]}, {31'h0, m_p[1]});
        end

        // Mid-cycle asynchronous reset while a write and pending set are in flight.
        rd_en = 2'b11; wr_en = 2'b11; wa0 = 4'd2; wd0 = 16'hBEEF; wa1 = 4'd6; wd1 = 16'hCAFE;
        setp = 1'b1; pa = 4'd6;
        #2;
        RST_N = 1'b0;
        #1;
        check("async_rst_d", out_ReadData, 32'h0);
        check("async_rst_p", {30'h0, out_ReadPend}, 32'h0);
        @(posedge CLK);
        #2;
        idle_inputs();
        model_reset();
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
        for (int r = 0; r < 16; r += 2) begin
            rd_en = 2'b11; ra0 = 4'(r); ra1 = 4'(r + 1); br = 1'b0;
            step();
            $display("rst read r%0d/r%0d: %h %h p=%b", r, r + 1, out_ReadData[15:0], out_ReadData[31:16], out_ReadPend);
            check($sformatf("rst_r%0d", r),     {16'h0, out_ReadData[15:0]},  (r == 2) ? 32'h03FF : 32'h0);
            check($sformatf("rst_r%0d", r + 1), {16'h0, out_ReadData[31:16]}, 32'h0);
            check($sformatf("rst_pend_r%0d", r), {30'h0, out_ReadPend}, 32'h0);
        end

        // Short random burst after reset to confirm normal operation resumes.
        for (int c = 0; c < 100; c++) begin
            rd_en = 2'($urandom); ra0 = 4'($urandom); ra1 = 4'($urandom);
            br = ($urandom_range(0, 3) == 0);
            wr_en = 2'($urandom); wa0 = 4'($urandom); wa1 = 4'($urandom);
            wd0 = 16'($urandom); wd1 = 16'($urandom);
            setp = ($urandom_range(0, 2) == 0); pa = 4'($urandom);
            step();
            $display("rnd2 %0d: d0=%h d1=%h p=%b", c, out_ReadData[15:0], out_ReadData[31:16], out_ReadPend);
            check("rnd2_d", out_ReadData, {m_d[1], m_d[0]});
            check("rnd2_p", {30'h0, out_ReadPend}, {30'h0, m_p[1], m_p[0]});
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
